// File: rtl/arb_pkg.sv
// arb_pkg: shared types and widths for the instruction/data memory arbiter.
package arb_pkg;
  localparam int CNT_W = 4;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_t;
endpackage

// File: rtl/arb_lat_timer.sv
// arb_lat_timer: loadable up-counter flagging when an access reaches the memory latency.
module arb_lat_timer
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] lat_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q != '0 && cnt_q == lat_i;
  // Zero means idle; a start on the completion cycle reloads for back-to-back accesses.
  always_comb cnt_d = start_i ? CNT_W'(1) : (done_o || cnt_q == '0) ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one fixed-latency memory between fetch and data stages,
// data-first with a starvation override and fetch-response flush.
module imem_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  input  logic        f_flush,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);
  localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);
  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             flush_q, flush_d, we_q, we_d;
  logic             done, comp, arb_pt, f_win, d_win;
  arb_lat_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .start_i(m_req),
    .lat_i  (LAT),
    .done_o (done)
  );
  always_comb begin
    comp     = state_q == BUSY && done;
    arb_pt   = !rst && (state_q == IDLE || comp);
    f_win    = arb_pt && f_req && (!d_req || starve_q == SMAX);
    d_win    = arb_pt && d_req && !f_win;
    f_gnt    = f_win;
    d_gnt    = d_win;
    m_req    = f_win || d_win;
    m_we     = d_win && d_we;
    m_addr   = d_win ? d_addr : f_win ? f_addr : '0;
    m_wdata  = d_win ? d_wdata : '0;
    // A flush arriving on the completion cycle itself still kills the response.
    f_rvalid = comp && owner_q == OWN_F && !flush_q && !f_flush;
    f_rdata  = f_rvalid ? m_rdata : '0;
    d_rvalid = comp && owner_q == OWN_D;
    d_rdata  = d_rvalid && !we_q ? m_rdata : '0;
    state_d  = m_req ? BUSY : comp ? IDLE : state_q;
    owner_d  = f_win ? OWN_F : d_win ? OWN_D : comp ? OWN_NONE : owner_q;
    we_d     = m_req ? m_we : comp ? 1'b0 : we_q;
    starve_d = f_win ? '0 : (d_win && f_req && starve_q != SMAX) ? starve_q + CNT_W'(1) : starve_q;
    flush_d  = f_win ? f_flush : comp ? 1'b0 : flush_q || (f_flush && state_q == BUSY && owner_q == OWN_F);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
      flush_q  <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      flush_q  <= flush_d;
      we_q     <= we_d;
    end
  end
  assign busy = state_q == BUSY;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenario checks of imem_arbiter with MEM_LAT=2, STARVE_MAX=3.
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, f_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, m_req, m_we, busy;
  logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
  int          n_chk = 0, n_fail = 0;

  imem_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    f_req = 0; f_flush = 0; d_req = 0; d_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset;
    rst = 1; f_req = 1; d_req = 1; f_addr = 32'h40; d_addr = 32'h100;
    smp();
    n_chk++; if (f_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_fgnt got %h want 0", f_gnt); end
    n_chk++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_dgnt got %h want 0", d_gnt); end
    n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rst_mreq got %h want 0", m_req); end
    n_chk++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL rst_maddr got %h want 0", m_addr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %h want 0", busy); end
    do_reset();
  endtask

  task automatic test_fetch;
    do_reset();
    f_req = 1; f_addr = 32'h40; smp();
    n_chk++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL f1_gnt got %h want 1", f_gnt); end
    n_chk++; if (m_req !== 1'b1 || m_we !== 1'b0) begin n_fail++; $display("FAIL f1_mreq got %h/%h want 1/0", m_req, m_we); end
    n_chk++; if (m_addr !== 32'h40) begin n_fail++; $display("FAIL f1_maddr got %h want 40", m_addr); end
    tick(); f_req = 0; smp();
    n_chk++; if (busy !== 1'b1 || m_req !== 1'b0) begin n_fail++; $display("FAIL f2_busy got busy=%h mreq=%h want 1/0", busy, m_req); end
    n_chk++; if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL f2_rvalid got %h want 0", f_rvalid); end
    tick(); m_rdata = 32'h8C010004; smp();
    n_chk++; if (f_rvalid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL f3_rvalid got %h busy %h want 1/1", f_rvalid, busy); end
    n_chk++; if (f_rdata !== 32'h8C010004) begin n_fail++; $display("FAIL f3_rdata got %h want 8c010004", f_rdata); end
    tick(); m_rdata = '0; smp();
    n_chk++; if (busy !== 1'b0 || f_rvalid !== 1'b0) begin n_fail++; $display("FAIL f4_idle got busy %h rvalid %h want 0/0", busy, f_rvalid); end
  endtask

  task automatic test_collision;
    do_reset();
    f_req = 1; f_addr = 32'h80; d_req = 1; d_addr = 32'h100; smp();
    n_chk++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin n_fail++; $display("FAIL c1_gnt got d=%h f=%h want 1/0", d_gnt, f_gnt); end
    n_chk++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL c1_maddr got %h want 100", m_addr); end
    tick(); d_req = 0; smp();
    n_chk++; if (dut.starve_q !== 4'd1) begin n_fail++; $display("FAIL c2_starve got %0d want 1", dut.starve_q); end
    n_chk++; if (f_gnt !== 1'b0) begin n_fail++; $display("FAIL c2_fgnt got %h want 0", f_gnt); end
    tick(); m_rdata = 32'h11111111; smp();
    n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11111111) begin n_fail++; $display("FAIL c3_drv got %h/%h want 1/11111111", d_rvalid, d_rdata); end
    n_chk++; if (f_gnt !== 1'b1 || m_addr !== 32'h80 || f_rvalid !== 1'b0) begin n_fail++; $display("FAIL c3_fgnt got %h addr %h frv %h want 1/80/0", f_gnt, m_addr, f_rvalid); end
    tick(); f_req = 0; m_rdata = '0; smp();
    n_chk++; if (dut.starve_q !== 4'd0) begin n_fail++; $display("FAIL c4_starve got %0d want 0", dut.starve_q); end
    tick(); m_rdata = 32'h22222222; smp();
    n_chk++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h22222222 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL c5_frv got %h/%h drv %h want 1/22222222/0", f_rvalid, f_rdata, d_rvalid); end
  endtask

  task automatic test_starvation;
    logic ed, ef;
    do_reset();
    f_req = 1; f_addr = 32'h10; d_req = 1; d_addr = 32'h20;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      smp();
      ed = (c % 2 == 1) && (c != 7);
      ef = (c == 7);
      n_chk++; if (d_gnt !== ed || f_gnt !== ef) begin n_fail++; $display("FAIL starve_c%0d got d=%h f=%h want d=%h f=%h", c, d_gnt, f_gnt, ed, ef); end
    end
  endtask

  task automatic test_flush;
    int mreqs;
    do_reset();
    f_req = 1; f_addr = 32'h300; smp();
    n_chk++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL fl1_gnt got %h want 1", f_gnt); end
    mreqs = int'(m_req);
    tick(); f_req = 0; f_flush = 1; smp();
    mreqs += int'(m_req);
    tick(); f_flush = 0; f_req = 1; f_addr = 32'h304; m_rdata = 32'hAAAA0000; smp();
    n_chk++; if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL fl3_rvalid got %h want 0", f_rvalid); end
    n_chk++; if (mreqs != 1) begin n_fail++; $display("FAIL fl_mreq_count got %0d want 1", mreqs); end
    n_chk++; if (f_gnt !== 1'b1 || m_addr !== 32'h304) begin n_fail++; $display("FAIL fl3_regnt got %h addr %h want 1/304", f_gnt, m_addr); end
    tick(); f_req = 0; m_rdata = '0; smp();
    tick(); m_rdata = 32'hBBBB0000; smp();
    n_chk++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hBBBB0000) begin n_fail++; $display("FAIL fl5_rvalid got %h/%h want 1/bbbb0000", f_rvalid, f_rdata); end
  endtask

  task automatic test_store;
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; smp();
    n_chk++; if (d_gnt !== 1'b1 || m_we !== 1'b1) begin n_fail++; $display("FAIL st1_gnt got %h we %h want 1/1", d_gnt, m_we); end
    n_chk++; if (m_addr !== 32'h200 || m_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL st1_bus got %h/%h want 200/deadbeef", m_addr, m_wdata); end
    tick(); d_req = 0; f_flush = 1; smp();
    n_chk++; if (m_we !== 1'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin n_fail++; $display("FAIL st2_bus got %h/%h/%h want 0/0/0", m_we, m_addr, m_wdata); end
    tick(); f_flush = 0; m_rdata = 32'h12345678; smp();
    n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL st3_done got %h/%h want 1/0", d_rvalid, d_rdata); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    f_req = 1; f_addr = 32'h500; smp();
    n_chk++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL rm1_gnt got %h want 1", f_gnt); end
    tick(); #2 rst = 1; #1;
    n_chk++; if (busy !== 1'b0 || f_gnt !== 1'b0 || m_req !== 1'b0 || m_addr !== 32'h0) begin n_fail++; $display("FAIL rm2_async got busy %h gnt %h mreq %h addr %h want 0", busy, f_gnt, m_req, m_addr); end
    tick(); m_rdata = 32'hFFFF0000; smp();
    n_chk++; if (f_rvalid !== 1'b0 || f_rdata !== 32'h0) begin n_fail++; $display("FAIL rm3_rvalid got %h/%h want 0/0", f_rvalid, f_rdata); end
    tick(); rst = 0; m_rdata = '0; smp();
    n_chk++; if (f_gnt !== 1'b1 || m_addr !== 32'h500) begin n_fail++; $display("FAIL rm4_regnt got %h addr %h want 1/500", f_gnt, m_addr); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
